tx_pkt_cap2kx32: RTL and testbench
==================================

Name: tx_pkt_cap2kx32

Overview:
Transmit-side capture buffer for the PHY emulator. It is the counterpart of the RX packet generator memory: that memory feeds packets into the MAC, and this block accepts packets the MAC transmits toward the PHY.
- Stores packets in an internal 2048x32 dual-port RAM, with a per-packet length queue.
- Drops packets that cannot fit, rolling back to the last committed packet.
- Presents complete packets only, word by word, to a test/host reader.

Parameters:
DATAWIDTH, 32, width of a data word
ADDRWIDTH, 11, RAM address width
ADDRDEPTH, 2048, RAM depth in words
MAXPKTS, 16, depth of the length (descriptor) queue; power of 2
LENWIDTH, 14, width of the byte length field

Ports:
clock  in  1  single clock for all logic
reset  in  1  synchronous, active-high reset
tx_valid  in  1  word qualifier from MAC TX
tx_sop  in  1  first word of packet
tx_eop  in  1  last word of packet
tx_mod  in  2  valid bytes in eop word; 0 means 4, 1..3 means that count
tx_data  in  DATAWIDTH  packet word
rd_en  in  1  pop one word of the head packet
rd_pkt_avail  out  1  at least one committed packet stored
rd_len  out  LENWIDTH  byte length of head packet; valid while rd_pkt_avail
rd_valid  out  1  rd_data valid
rd_data  out  DATAWIDTH  read word
rd_last  out  1  rd_data is the final word of its packet
pkt_cnt  out  5  committed packets stored (0..MAXPKTS)
pkt_drop_cnt  out  16  dropped packets, saturating at 0xFFFF

Behaviour:
- Reset: every output is 0. wr_ptr, commit_ptr and rd_ptr are 0, the queue is emptied and the FSM goes to IDLE. RAM contents are don't-care. Reset mid-capture or mid-read discards everything.
- Pointers are ADDRWIDTH+1 bits wide, and RAM is addressed by the low ADDRWIDTH bits.
  - Full when wr_ptr-rd_ptr == ADDRDEPTH.
  - Space is evaluated on the pre-edge rd_ptr; a same-cycle read does not free space for a same-cycle write.
- No backpressure: the MAC may present a word every cycle.
- Write FSM, states IDLE, CAPT, DISCARD:
  - IDLE:
    - tx_valid & !tx_sop: ignored.
    - tx_valid & tx_sop: write the word at wr_ptr, set word count to 1, go to CAPT.
    - If tx_eop is also set, commit immediately and stay in IDLE.
  - CAPT, tx_valid & !tx_sop: write the word and increment the word count. If tx_eop, commit and go to IDLE.
  - CAPT, tx_valid & tx_sop (protocol error): abort the current packet as a drop (rollback, drop_cnt+1). The new word starts a fresh packet, following the IDLE rules, in the same cycle.
  - Overflow: a word arrives with the buffer full, or eop arrives with the queue holding MAXPKTS entries.
    - Roll wr_ptr back to commit_ptr and increment drop_cnt.
    - If that word was not eop, go to DISCARD; otherwise go to IDLE.
  - DISCARD: ignore words until tx_valid & tx_eop, then go to IDLE. A tx_sop seen in DISCARD restarts capture per the IDLE rules.
  - Commit: push len = (words-1)*4 + (tx_mod==0 ? 4 : tx_mod) into the queue, and set commit_ptr = wr_ptr+1 (post-write).
  - rd_pkt_avail and pkt_cnt update the cycle after the committing edge.
- Read side:
  - rd_en while rd_pkt_avail reads RAM[rd_ptr] and increments rd_ptr.
  - rd_data, rd_valid and rd_last appear 1 cycle after rd_en (registered RAM output).
  - rd_en with !rd_pkt_avail is ignored, and rd_valid stays 0.
  - A read counter tracks words of the head packet against ceil(len/4).
    - On the final word, rd_last=1 with that word, and the descriptor pops on the same edge as rd_en.
    - The next rd_len and rd_pkt_avail are valid the following cycle.
  - The reader never sees uncommitted data, because reads are bounded by the committed length.
- Simultaneous commit and pop: pkt_cnt is unchanged and the queue stays consistent.
- Packets longer than ADDRDEPTH words always overflow and are dropped.
- Width: len fits in LENWIDTH because the maximum is 8192 bytes.

Test Plan:
1. 16-word packet, tx_mod=0, data 0x00000000..0x0000000F.
   -> rd_pkt_avail=1 and pkt_cnt=1 the cycle after eop; rd_len=64.
   -> 16 rd_en pulses return the data in order, with rd_last on word 16; pkt_cnt=0 afterward.
2. Single word with sop&eop, tx_mod=1, data 0xA5A5A5A5.
   -> rd_len=1; one read returns 0xA5A5A5A5 with rd_last=1.
3. Overflow:
   - Store a 2040-word packet, no reads, then send a 20-word packet.
   - -> pkt_drop_cnt=1, pkt_cnt=1, FSM in DISCARD until eop.
   - -> A following 8-word packet is stored, with wr_ptr correctly rolled back.
   - -> Both stored packets read back intact.
4. Protocol error: 5 words, then a new sop for a 3-word packet, mod=2.
   -> drop_cnt=1, pkt_cnt=1, rd_len=10, 3 correct words read.
5. Queue limit: 16 one-word packets stored, then a 17th.
   -> the 17th is dropped (drop_cnt=1, pkt_cnt=16); after one packet is read, an 18th is accepted.
6. Reset asserted mid-capture and mid-read for 1 cycle.
   -> all outputs 0, pkt_cnt=0, rd_valid=0.
   -> The next packet captures and reads back correctly.

Source files
------------

// File: rtl/tx_pkt_cap2kx32_if.sv
// MAC TX capture port, host read port and status counters of the capture buffer.
interface tx_pkt_cap2kx32_if #(
  parameter int DATAWIDTH = 32,
  parameter int LENWIDTH  = 14
);
  logic                 tx_valid;
  logic                 tx_sop;
  logic                 tx_eop;
  logic [1:0]           tx_mod;
  logic [DATAWIDTH-1:0] tx_data;
  logic                 rd_en;
  logic                 rd_pkt_avail;
  logic [LENWIDTH-1:0]  rd_len;
  logic                 rd_valid;
  logic [DATAWIDTH-1:0] rd_data;
  logic                 rd_last;
  logic [4:0]           pkt_cnt;
  logic [15:0]          pkt_drop_cnt;

  modport master (
    output tx_valid, tx_sop, tx_eop, tx_mod, tx_data, rd_en,
    input  rd_pkt_avail, rd_len, rd_valid, rd_data, rd_last, pkt_cnt, pkt_drop_cnt
  );

  modport slave (
    input  tx_valid, tx_sop, tx_eop, tx_mod, tx_data, rd_en,
    output rd_pkt_avail, rd_len, rd_valid, rd_data, rd_last, pkt_cnt, pkt_drop_cnt
  );
endinterface

// File: rtl/tx_pkt_cap2kx32.sv
// TX packet capture buffer: 2Kx32 RAM plus a length queue. Packets are
// written as they arrive, committed on eop, rolled back on overflow or a
// protocol error, and handed to the reader only once complete.
module tx_pkt_cap2kx32 #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 11,
  parameter int ADDRDEPTH = 2048,
  parameter int MAXPKTS   = 16,
  parameter int LENWIDTH  = 14
) (
  input  logic clock,
  input  logic reset,
  tx_pkt_cap2kx32_if.slave bus
);
  localparam int PW  = ADDRWIDTH + 1;
  localparam int QAW = $clog2(MAXPKTS);
  localparam int QW  = QAW + 1;

  typedef enum logic [1:0] {IDLE, CAPT, DISCARD} st_t;
  st_t st, st_n;

  logic [DATAWIDTH-1:0] mem  [ADDRDEPTH];
  logic [LENWIDTH-1:0]  lenq [MAXPKTS];

  logic [PW-1:0] wr_ptr, wr_ptr_n, commit_ptr, commit_ptr_n, rd_ptr;
  logic [PW-1:0] wbase, wcnt, wcnt_n, wwords, rd_wcnt, head_words;
  logic [QW-1:0] q_wp, q_rp, qcnt;
  logic [LENWIDTH-1:0] plen, head_len;
  logic [1:0]  drop_inc;
  logic [16:0] drop_sum;
  logic [15:0] drop_cnt;
  logic we, push, pop, rd_fire, head_last, full, qfull, active;
  logic rd_valid_q, rd_last_q;
  logic [DATAWIDTH-1:0] rd_data_q;

  assign qcnt       = q_wp - q_rp;
  assign qfull      = qcnt == QW'(MAXPKTS);
  assign head_len   = lenq[q_rp[QAW-1:0]];
  assign head_words = PW'((head_len + LENWIDTH'(3)) >> 2);
  assign head_last  = rd_wcnt == head_words - PW'(1);
  assign rd_fire    = bus.rd_en && (qcnt != '0);
  assign pop        = rd_fire && head_last;
  assign drop_sum   = {1'b0, drop_cnt} + 17'(drop_inc);

  assign bus.rd_pkt_avail = qcnt != '0;
  assign bus.rd_len       = (qcnt != '0) ? head_len : '0;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.rd_last      = rd_last_q;
  assign bus.pkt_cnt      = 5'(qcnt);
  assign bus.pkt_drop_cnt = drop_cnt;

  // Write-side next state: a sop always restarts at commit_ptr (aborting any
  // open packet); overflow rolls back to commit_ptr. Space uses pre-edge rd_ptr.
  always_comb begin
    st_n         = st;
    wr_ptr_n     = wr_ptr;
    commit_ptr_n = commit_ptr;
    wcnt_n       = wcnt;
    we           = 1'b0;
    push         = 1'b0;
    drop_inc     = 2'd0;
    active       = bus.tx_valid && (bus.tx_sop || st == CAPT);
    wbase        = bus.tx_sop ? commit_ptr : wr_ptr;
    wwords       = bus.tx_sop ? PW'(1) : wcnt + PW'(1);
    full         = (wbase - rd_ptr) == PW'(ADDRDEPTH);
    plen         = LENWIDTH'({wwords - PW'(1), 2'b00}) +
                   LENWIDTH'((bus.tx_mod == 2'd0) ? 3'd4 : {1'b0, bus.tx_mod});
    if (bus.tx_valid && bus.tx_sop && st == CAPT) drop_inc = 2'd1;
    if (active) begin
      if (full || (bus.tx_eop && qfull)) begin
        drop_inc = drop_inc + 2'd1;
        wr_ptr_n = commit_ptr;
        st_n     = bus.tx_eop ? IDLE : DISCARD;
      end else begin
        we       = 1'b1;
        wr_ptr_n = wbase + PW'(1);
        if (bus.tx_eop) begin
          push         = 1'b1;
          commit_ptr_n = wbase + PW'(1);
          st_n         = IDLE;
        end else begin
          wcnt_n = wwords;
          st_n   = CAPT;
        end
      end
    end else if (bus.tx_valid && bus.tx_eop && st == DISCARD) begin
      st_n = IDLE;
    end
  end

  // Write-side state, pointers, queue write pointer and saturating drop count.
  always_ff @(posedge clock) begin
    if (reset) begin
      st         <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      wcnt       <= '0;
      q_wp       <= '0;
      drop_cnt   <= '0;
    end else begin
      st         <= st_n;
      wr_ptr     <= wr_ptr_n;
      commit_ptr <= commit_ptr_n;
      wcnt       <= wcnt_n;
      if (push) q_wp <= q_wp + QW'(1);
      if (drop_inc != 2'd0) drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  // Packet RAM and length queue writes (contents need no reset).
  always_ff @(posedge clock) begin
    if (we)   mem[wbase[ADDRWIDTH-1:0]] <= bus.tx_data;
    if (push) lenq[q_wp[QAW-1:0]]       <= plen;
  end

  // Read side: registered RAM output, per-packet word counter, descriptor pop
  // on the edge that consumes the final word.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr     <= '0;
      rd_wcnt    <= '0;
      q_rp       <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_fire;
      rd_last_q  <= pop;
      if (rd_fire) begin
        rd_data_q <= mem[rd_ptr[ADDRWIDTH-1:0]];
        rd_ptr    <= rd_ptr + PW'(1);
        rd_wcnt   <= head_last ? '0 : rd_wcnt + PW'(1);
      end
      if (pop) q_rp <= q_rp + QW'(1);
    end
  end
endmodule

// File: tb/tb_tx_pkt_cap2kx32.sv
// Bench for tx_pkt_cap2kx32: directed packets, read expectations queued in a
// scoreboard and checked by a monitor whenever rd_valid is seen.
module tb_tx_pkt_cap2kx32;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  int exp_drop = 0;
  logic [32:0] sb [$];

  tx_pkt_cap2kx32_if #(.DATAWIDTH(32), .LENWIDTH(14)) b ();

  tx_pkt_cap2kx32 dut (.clock(clock), .reset(reset), .bus(b));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic s, input logic e, input logic [1:0] m, input logic [31:0] d);
    b.tx_valid = 1'b1; b.tx_sop = s; b.tx_eop = e; b.tx_mod = m; b.tx_data = d;
    tick();
    b.tx_valid = 1'b0; b.tx_sop = 1'b0; b.tx_eop = 1'b0;
  endtask

  // n words with data base+i; eop on the last word only when close is set
  task automatic send(input int n, input logic [1:0] m, input logic [31:0] base, input bit close);
    for (int i = 0; i < n; i++)
      wr(i == 0, close && (i == n - 1), m, base + 32'(i));
  endtask

  task automatic rd(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      b.rd_en = 1'b1;
      sb.push_back({(i == n - 1), base + 32'(i)});
      tick();
      b.rd_en = 1'b0;
    end
  endtask

  task automatic drain();
    tick(); tick();
  endtask

  // Monitor: every rd_valid must match the oldest expectation
  always @(negedge clock) begin
    logic [32:0] e;
    if (b.rd_valid) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL rd_unexpected: got data 0x%0h with nothing expected", b.rd_data);
      end else begin
        e = sb.pop_front();
        chk("rd_data", b.rd_data, e[31:0]);
        chk("rd_last", 32'(b.rd_last), 32'(e[32]));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    b.tx_valid = 0; b.tx_sop = 0; b.tx_eop = 0; b.tx_mod = 0; b.tx_data = 0; b.rd_en = 0;
    tick(); tick(); tick();
    reset = 1'b0;
    chk("rst_avail", 32'(b.rd_pkt_avail), 0);
    chk("rst_len", 32'(b.rd_len), 0);
    chk("rst_valid", 32'(b.rd_valid), 0);
    chk("rst_data", b.rd_data, 0);
    chk("rst_cnt", 32'(b.pkt_cnt), 0);
    chk("rst_drop", 32'(b.pkt_drop_cnt), 0);

    // 1: 16-word packet
    send(16, 2'd0, 32'h0, 1);
    chk("t1_avail", 32'(b.rd_pkt_avail), 1);
    chk("t1_cnt", 32'(b.pkt_cnt), 1);
    chk("t1_len", 32'(b.rd_len), 64);
    rd(16, 32'h0);
    drain();
    chk("t1_cnt_after", 32'(b.pkt_cnt), 0);

    // 2: single word sop&eop, mod 1
    wr(1, 1, 2'd1, 32'hA5A5A5A5);
    chk("t2_len", 32'(b.rd_len), 1);
    rd(1, 32'hA5A5A5A5);
    drain();

    // 3: overflow with rollback
    send(2040, 2'd0, 32'h1000_0000, 1);
    chk("t3_len_big", 32'(b.rd_len), 8160);
    send(20, 2'd0, 32'h1100_0000, 1);
    exp_drop++;
    chk("t3_drop", 32'(b.pkt_drop_cnt), 32'(exp_drop));
    chk("t3_cnt", 32'(b.pkt_cnt), 1);
    send(8, 2'd0, 32'h2000_0000, 1);
    chk("t3_cnt2", 32'(b.pkt_cnt), 2);
    rd(2040, 32'h1000_0000);
    drain();
    chk("t3_len_small", 32'(b.rd_len), 32);
    rd(8, 32'h2000_0000);
    drain();

    // 4: protocol error, new sop mid-packet
    send(5, 2'd0, 32'h3000_0000, 0);
    send(3, 2'd2, 32'h4000_0000, 1);
    exp_drop++;
    chk("t4_drop", 32'(b.pkt_drop_cnt), 32'(exp_drop));
    chk("t4_cnt", 32'(b.pkt_cnt), 1);
    chk("t4_len", 32'(b.rd_len), 10);
    rd(3, 32'h4000_0000);
    drain();

    // 5: length queue limit
    for (int i = 0; i < 16; i++) wr(1, 1, 2'd0, 32'h5000 + 32'(i));
    chk("t5_cnt16", 32'(b.pkt_cnt), 16);
    wr(1, 1, 2'd0, 32'h5100);
    exp_drop++;
    chk("t5_drop", 32'(b.pkt_drop_cnt), 32'(exp_drop));
    chk("t5_cnt_full", 32'(b.pkt_cnt), 16);
    rd(1, 32'h5000);
    drain();
    chk("t5_cnt15", 32'(b.pkt_cnt), 15);
    wr(1, 1, 2'd0, 32'h5200);
    chk("t5_cnt_again", 32'(b.pkt_cnt), 16);
    for (int i = 1; i < 16; i++) rd(1, 32'h5000 + 32'(i));
    rd(1, 32'h5200);
    drain();
    chk("t5_cnt_empty", 32'(b.pkt_cnt), 0);

    // 6: reset mid-read and mid-capture
    send(4, 2'd0, 32'h6000, 1);
    rd(2, 32'h6000);
    sb.pop_back();
    sb.push_back({1'b0, 32'h6001});
    drain();
    send(3, 2'd0, 32'h6100, 0);
    reset = 1'b1; b.rd_en = 1'b1;
    b.tx_valid = 1'b1; b.tx_data = 32'h6103;
    tick();
    reset = 1'b0; b.rd_en = 1'b0; b.tx_valid = 1'b0;
    exp_drop = 0;
    chk("t6_valid", 32'(b.rd_valid), 0);
    chk("t6_data", b.rd_data, 0);
    chk("t6_last", 32'(b.rd_last), 0);
    chk("t6_avail", 32'(b.rd_pkt_avail), 0);
    chk("t6_cnt", 32'(b.pkt_cnt), 0);
    chk("t6_drop", 32'(b.pkt_drop_cnt), 0);
    send(5, 2'd3, 32'h7000, 1);
    chk("t6_len", 32'(b.rd_len), 19);
    rd(5, 32'h7000);
    drain();
    chk("t6_cnt_after", 32'(b.pkt_cnt), 0);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
